// File: rtl/date_to_doy.sv
// Calendar date (binary month, BCD day-of-month, leap flag) to day-of-year,
// produced in binary and 3-digit BCD through a start/busy/done handshake.
module date_to_doy #(
  parameter int unsigned YEAR_BASE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  month,
  input  logic [7:0]  dom,
  input  logic        leap,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  doy_bin,
  output logic [11:0] doy_bcd
);

  typedef enum logic [2:0] {IDLE, CHECK, ACCUM, BCD, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  month_q;
  logic [7:0]  dom_q;
  logic        leap_q;
  logic [3:0]  m_q;
  logic [8:0]  acc_q;
  logic [11:0] bcd_q;
  logic [3:0]  cnt_q;

  logic [7:0]  d;
  logic        invalid;
  logic [8:0]  acc_rot;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_shift;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: return 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    return 5'd30;
      4'd2:                                       return lp ? 5'd29 : 5'd28;
      default:                                    return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] x);
    return (x >= 4'd5) ? x + 4'd3 : x;
  endfunction

  assign d = {4'd0, dom_q[7:4]} * 8'd10 + {4'd0, dom_q[3:0]};

  assign invalid = (month_q == 4'd0) || (month_q > 4'd12) ||
                   (dom_q[3:0] > 4'd9) || (dom_q[7:4] > 4'd3) ||
                   (d == 8'd0) || (d > {3'd0, month_len(month_q, leap_q)});

  // acc is rotated rather than shifted during BCD: nine rotations restore the
  // original value, so the binary result is still available at the last step.
  assign acc_rot   = {acc_q[7:0], acc_q[8]};
  assign bcd_adj   = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};
  assign bcd_shift = {bcd_adj[10:0], acc_q[8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   if (invalid)              state_next = DONE;
               else if (month_q > 4'd1)  state_next = ACCUM;
               else                      state_next = BCD;
      ACCUM:   if (m_q == month_q - 4'd1) state_next = BCD;
      BCD:     if (cnt_q == 4'd8) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      month_q <= '0;
      dom_q   <= '0;
      leap_q  <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      err     <= 1'b0;
      doy_bin <= '0;
      doy_bcd <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          month_q <= month;
          dom_q   <= dom;
          leap_q  <= leap;
        end
        CHECK: begin
          acc_q <= 9'(d) - 9'd1 + 9'(YEAR_BASE);
          m_q   <= 4'd1;
          bcd_q <= '0;
          cnt_q <= '0;
          if (invalid) err <= 1'b1;
        end
        ACCUM: begin
          acc_q <= acc_q + {4'd0, month_len(m_q, leap_q)};
          m_q   <= m_q + 4'd1;
        end
        BCD: begin
          bcd_q <= bcd_shift;
          acc_q <= acc_rot;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            doy_bin <= acc_rot;
            doy_bcd <= bcd_shift;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_date_to_doy.sv
// Self-checking bench for date_to_doy: directed cases plus random dates,
// two instances (YEAR_BASE=1 and 0) compared against a calendar model.
module tb_date_to_doy;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  month = '0;
  logic [7:0]  dom = '0;
  logic        leap = 1'b0;

  logic        busy1, done1, err1, busy0, done0, err0;
  logic [8:0]  bin1, bin0;
  logic [11:0] bcd1, bcd0;

  int errors = 0;
  int checks = 0;
  int exp_bin1 = 0;
  int exp_bin0 = 0;
  int exp_err = 0;

  date_to_doy #(.YEAR_BASE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .month(month), .dom(dom), .leap(leap),
    .busy(busy1), .done(done1), .err(err1), .doy_bin(bin1), .doy_bcd(bcd1));

  date_to_doy #(.YEAR_BASE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .month(month), .dom(dom), .leap(leap),
    .busy(busy0), .done(done0), .err(err0), .doy_bin(bin0), .doy_bcd(bcd0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mlen(input int m, input bit lp);
    int days [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && lp) return 29;
    return days[m-1];
  endfunction

  function automatic void model(input int mo, input logic [7:0] dm, input bit lp,
                                input int yb, output bit bad, output int doy);
    int tens = int'(dm[7:4]);
    int ones = int'(dm[3:0]);
    int dd   = tens * 10 + ones;
    bad = (mo < 1) || (mo > 12) || (ones > 9) || (tens > 3) || (dd == 0);
    if (!bad) bad = dd > mlen(mo, lp);
    doy = dd - 1 + yb;
    if (!bad) for (int k = 1; k < mo; k++) doy += mlen(k, lp);
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_err1"}, err1, exp_err);
    check({tag, "_err0"}, err0, exp_err);
    check({tag, "_bin1"}, bin1, exp_bin1);
    check({tag, "_bcd1"}, bcd1, to_bcd(exp_bin1));
    check({tag, "_bin0"}, bin0, exp_bin0);
    check({tag, "_bcd0"}, bcd0, to_bcd(exp_bin0));
  endtask

  task automatic run(input logic [3:0] mo, input logic [7:0] dm, input logic lp);
    bit bad1, bad0;
    int v1, v0, lat, exp_lat;
    model(int'(mo), dm, lp, 1, bad1, v1);
    model(int'(mo), dm, lp, 0, bad0, v0);
    exp_err = bad1 ? 1 : 0;
    if (!bad1) begin
      exp_bin1 = v1;
      exp_bin0 = v0;
    end
    exp_lat = bad1 ? 1 : int'(mo) + 9;
    @(negedge clk);
    month = mo; dom = dm; leap = lp; start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", busy1, 1);
    @(negedge clk);
    start = 1'b0;
    month = 4'($urandom); dom = 8'($urandom); leap = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done1 && lat < 40);
    check("latency", lat, exp_lat);
    check("done1", done1, 1);
    check("done0", done0, 1);
    check_outputs("result");
    @(posedge clk); #1;
    check("done_one_cycle", done1, 0);
    check("busy_back_idle", busy1, 0);
  endtask

  initial begin
    int n_done, last, n;
    repeat (2) @(posedge clk);
    #1;
    check("in_reset_busy", busy1, 0);
    check_outputs("in_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", busy1, 0);
    check("post_reset_done", done1, 0);
    check_outputs("post_reset");

    // Directed calendar boundaries
    run(4'd1, 8'h01, 1'b0);
    check("jan1_bin_const", bin1, 1);
    run(4'd3, 8'h01, 1'b0);
    run(4'd3, 8'h01, 1'b1);
    run(4'd12, 8'h31, 1'b1);
    check("leap_dec31_const", bin1, 366);
    check("leap_dec31_bcd_const", bcd1, 12'h366);
    run(4'd12, 8'h31, 1'b0);
    check("dec31_yb0_const", bin0, 364);
    run(4'd2, 8'h29, 1'b1);

    // Error path keeps the last valid result
    run(4'd3, 8'h01, 1'b0);
    run(4'd2, 8'h29, 1'b0);
    check("err_holds_60", bin1, 60);
    run(4'd13, 8'h01, 1'b0);
    run(4'd1, 8'h1A, 1'b0);
    run(4'd1, 8'h00, 1'b0);
    run(4'd4, 8'h31, 1'b0);
    run(4'd0, 8'h10, 1'b0);
    run(4'd1, 8'h40, 1'b0);

    // start held high: one done per return to IDLE, 17 edges apart
    @(negedge clk);
    month = 4'd6; dom = 8'h15; leap = 1'b0; start = 1'b1;
    exp_bin1 = 166; exp_bin0 = 165; exp_err = 0;
    n_done = 0; last = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done1) begin
        n_done++;
        check_outputs("hold");
        if (last >= 0) check("hold_gap", i - last, 17);
        else           check("hold_first", i, 15);
        last = i;
      end
    end
    check("hold_count", n_done, 3);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_drain_idle", busy1, 0);

    // Leave a nonzero result and err=1 so the reset clear is observable
    run(4'd3, 8'h01, 1'b0);
    run(4'd4, 8'h31, 1'b0);

    // Reset in the middle of ACCUM
    @(negedge clk);
    month = 4'd9; dom = 8'h20; leap = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_abort_busy", busy1, 1);
    rst = 1'b0;
    #1;
    exp_bin1 = 0; exp_bin0 = 0; exp_err = 0;
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check_outputs("abort");
    n_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done1 || done0) n_done++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (done1 || done0) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check_outputs("abort_after_release");
    run(4'd9, 8'h20, 1'b1);

    // Random dates, mostly plausible, some malformed
    for (int i = 0; i < 30; i++) begin
      logic [3:0] mo;
      logic [7:0] dm;
      logic       lp;
      mo = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 12)) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0)
        dm = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
      else
        dm = 8'($urandom);
      lp = 1'($urandom_range(0, 1));
      run(mo, dm, lp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
